// File: rtl/agg_ctrl.sv
// ---------------------------------------------------------------------------
// agg_ctrl : sequencing controller for the aggregator datapath.
// For each output neuron it counts num_terms partial sums into the aggregator,
// offers the finished result to the activation stage under valid/ready, and
// steps through num_outputs neurons before pulsing done.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 layer start pulse (honoured only in IDLE)
//   num_terms/num_outputs layer lengths, latched on an accepted start
//   in_valid / in_ready   partial-sum handshake
//   agg_en / agg_clr      aggregator accumulate / load strobes (combinational)
//   act_valid / act_ready result handshake towards the activation stage
//   out_idx               index of the output in progress
//   busy, done            not-IDLE flag, end-of-layer pulse
//   stall_cnt             (only with AGG_CTRL_PERF_EN) saturating stall counter
//
// Build option: define AGG_CTRL_PERF_EN to add the stall_cnt port.
// ---------------------------------------------------------------------------
module agg_ctrl #(
  parameter int unsigned cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [cnt_width-1:0] num_terms,
  input  logic [cnt_width-1:0] num_outputs,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 agg_en,
  output logic                 agg_clr,
  output logic                 act_valid,
  input  logic                 act_ready,
  output logic [cnt_width-1:0] out_idx,
  output logic                 busy,
`ifdef AGG_CTRL_PERF_EN
  output logic                 done,
  output logic [15:0]          stall_cnt
`else
  output logic                 done
`endif
);

  localparam int unsigned StallW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [cnt_width-1:0] term_cnt_q, term_cnt_d;
  logic [cnt_width-1:0] out_idx_q, out_idx_d;
  logic [cnt_width-1:0] num_terms_q, num_terms_d;
  logic [cnt_width-1:0] num_outputs_q, num_outputs_d;
  logic                 in_ready_q, act_valid_q, busy_q, done_q;

  logic start_ok;
  logic last_term;
  logic last_out;

  // Lengths are non-zero whenever they are compared, so the -1 never wraps.
  assign start_ok  = start && (num_terms != '0) && (num_outputs != '0);
  assign last_term = (term_cnt_q == cnt_width'(num_terms_q - cnt_width'(1)));
  assign last_out  = (out_idx_q == cnt_width'(num_outputs_q - cnt_width'(1)));

`ifdef AGG_CTRL_PERF_EN
  logic [StallW-1:0] stall_q, stall_d;
  logic              stall_ev;

  // Stall: ACC waiting on input, or DRAIN waiting on the activation stage.
  assign stall_ev = ((state_q == ACC) && !in_valid) ||
                    ((state_q == DRAIN) && !act_ready);

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start_ok) begin
      stall_d = '0;
    end else if (stall_ev && (stall_q != {StallW{1'b1}})) begin
      stall_d = StallW'(stall_q + StallW'(1));
    end
  end

  assign stall_cnt = stall_q;
`endif

  // Next-state and counter update.
  always_comb begin
    state_d       = state_q;
    term_cnt_d    = term_cnt_q;
    out_idx_d     = out_idx_q;
    num_terms_d   = num_terms_q;
    num_outputs_d = num_outputs_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          num_terms_d   = num_terms;
          num_outputs_d = num_outputs;
          term_cnt_d    = '0;
          out_idx_d     = '0;
          state_d       = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          if (last_term) begin
            term_cnt_d = '0;
            state_d    = DRAIN;
          end else begin
            term_cnt_d = cnt_width'(term_cnt_q + cnt_width'(1));
          end
        end
      end
      DRAIN: begin
        if (act_ready) begin
          if (last_out) begin
            state_d = DONE;
          end else begin
            out_idx_d = cnt_width'(out_idx_q + cnt_width'(1));
            state_d   = ACC;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and state-decoded outputs, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      term_cnt_q    <= '0;
      out_idx_q     <= '0;
      num_terms_q   <= '0;
      num_outputs_q <= '0;
      in_ready_q    <= 1'b0;
      act_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef AGG_CTRL_PERF_EN
      stall_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      term_cnt_q    <= term_cnt_d;
      out_idx_q     <= out_idx_d;
      num_terms_q   <= num_terms_d;
      num_outputs_q <= num_outputs_d;
      in_ready_q    <= (state_d == ACC);
      act_valid_q   <= (state_d == DRAIN);
      busy_q        <= (state_d != IDLE);
      done_q        <= (state_d == DONE);
`ifdef AGG_CTRL_PERF_EN
      stall_q       <= stall_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign act_valid = act_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_idx   = out_idx_q;

  // Strobes follow in_valid directly; in_ready_q is high exactly in ACC.
  assign agg_en  = in_valid & in_ready_q;
  assign agg_clr = agg_en & (term_cnt_q == '0);

endmodule

// File: tb/tb_agg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_agg_ctrl : self-checking bench for agg_ctrl (cnt_width = 8).
// A transaction-level model tracks terms seen / outputs finished per layer and
// predicts every output each cycle; directed scenarios are followed by
// randomized layers with random input gaps, backpressure and stray starts.
// ---------------------------------------------------------------------------
module tb_agg_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, act_ready;
  logic [7:0] num_terms, num_outputs;
  logic       in_ready, agg_en, agg_clr, act_valid, busy, done;
  logic [7:0] out_idx;
`ifdef AGG_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  agg_ctrl #(.cnt_width(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_terms  (num_terms),
    .num_outputs(num_outputs),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .agg_en     (agg_en),
    .agg_clr    (agg_clr),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .out_idx    (out_idx),
    .busy       (busy),
`ifdef AGG_CTRL_PERF_EN
    .done       (done),
    .stall_cnt  (stall_cnt)
`else
    .done       (done)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a layer is "active" until its last result is taken.
  // seen == n means the current output is complete and awaiting act_ready.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_n = 0, m_m = 0, m_seen = 0, m_idx = 0;
`ifdef AGG_CTRL_PERF_EN
  int m_stall = 0;
`endif

  int cyc_no  = 0;
  int done_at = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  task automatic check_outputs();
    bit e_rdy, e_val, e_en;
    e_rdy = m_active && (m_seen < m_n);
    e_val = m_active && (m_seen == m_n);
    e_en  = e_rdy && in_valid;
    chk("in_ready",  32'(in_ready),  32'(e_rdy));
    chk("act_valid", 32'(act_valid), 32'(e_val));
    chk("agg_en",    32'(agg_en),    32'(e_en));
    chk("agg_clr",   32'(agg_clr),   32'(e_en && (m_seen == 0)));
    chk("busy",      32'(busy),      32'(m_active || m_done));
    chk("done",      32'(done),      32'(m_done));
    chk("out_idx",   32'(out_idx),   32'(m_idx));
`ifdef AGG_CTRL_PERF_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    if (done === 1'b1) done_at = cyc_no;
  endtask

  task automatic model_step(input logic r, input logic s, input logic [7:0] nt,
                            input logic [7:0] no, input logic iv, input logic ar);
    if (r) begin
      m_active = 0; m_done = 0; m_seen = 0; m_idx = 0;
`ifdef AGG_CTRL_PERF_EN
      m_stall = 0;
`endif
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (s && nt != 0 && no != 0) begin
        m_active = 1; m_n = int'(nt); m_m = int'(no); m_seen = 0; m_idx = 0;
`ifdef AGG_CTRL_PERF_EN
        m_stall = 0;
`endif
      end
    end else if (m_seen < m_n) begin
      if (iv) m_seen++;
`ifdef AGG_CTRL_PERF_EN
      else if (m_stall < 65535) m_stall++;
`endif
    end else begin
      if (ar) begin
        if (m_idx == m_m - 1) begin
          m_active = 0; m_done = 1;
        end else begin
          m_idx++; m_seen = 0;
        end
      end
`ifdef AGG_CTRL_PERF_EN
      else if (m_stall < 65535) m_stall++;
`endif
    end
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic cyc(input logic r, input logic s, input logic [7:0] nt,
                     input logic [7:0] no, input logic iv, input logic ar);
    @(negedge clk);
    rst = r; start = s; num_terms = nt; num_outputs = no;
    in_valid = iv; act_ready = ar;
    #1;
    check_outputs();
    @(posedge clk);
    model_step(r, s, nt, no, iv, ar);
    cyc_no++;
  endtask

  // Run the current layer to IDLE; rnd selects random gaps, backpressure and
  // stray start pulses, otherwise in_valid/act_ready are held high.
  task automatic run_to_idle(input int budget, input bit rnd);
    int i;
    for (i = 0; i < budget && (m_active || m_done); i++) begin
      if (rnd)
        cyc(1'b0, ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 6)),
            8'($urandom_range(0, 5)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0));
      else
        cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
    end
    #1;
    chk("layer_ends_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [5:0] gap_pat;
    int         lim;
    gap_pat = 6'b101101;   // LSB first: 1,0,1,1,0,1
    rst = 1'b1; start = 1'b0; num_terms = '0; num_outputs = '0;
    in_valid = 1'b0; act_ready = 1'b0;

    // Reset and idle.
    @(posedge clk);
    model_step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

    // Basic layer: N=3, M=2, done expected 9 cycles after the start cycle.
    cyc_no = 0; done_at = -1;
    cyc(1'b0, 1'b1, 8'd3, 8'd2, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
    chk("basic_done_cycle", 32'(done_at), 32'd9);

    // Backpressure: N=2, M=1, act_ready low for 4 DRAIN cycles.
    cyc(1'b0, 1'b1, 8'd2, 8'd1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
`ifdef AGG_CTRL_PERF_EN
    #1;
    chk("stall_at_done", 32'(stall_cnt), 32'd4);
`endif
    run_to_idle(10, 1'b0);

    // Input gaps: N=4, in_valid 1,0,1,1,0,1.
    cyc(1'b0, 1'b1, 8'd4, 8'd1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'd0, 8'd0, gap_pat[i], 1'b1);
    #1;
    chk("gaps_in_drain", 32'(act_valid), 32'd1);
    run_to_idle(10, 1'b0);

    // Illegal start (num_terms=0), then a layer with a re-pulsed start in ACC.
    cyc(1'b0, 1'b1, 8'd0, 8'd3, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 8'd2, 8'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 8'd3, 8'd2, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 8'd1, 8'd1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'd7, 8'd9, 1'b1, 1'b1);
    run_to_idle(20, 1'b0);

    // Reset mid-layer in DRAIN with out_idx = 1.
    cyc(1'b0, 1'b1, 8'd2, 8'd3, 1'b1, 1'b1);
    lim = 0;
    while (!(m_active && m_seen == m_n && m_idx == 1) && lim < 20) begin
      cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
      lim++;
    end
    #1;
    chk("reached_drain_idx1", 32'(act_valid && out_idx == 8'd1), 32'd1);
    cyc(1'b1, 1'b1, 8'd2, 8'd3, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1);

    // Maximum lengths.
    cyc(1'b0, 1'b1, 8'd255, 8'd1, 1'b1, 1'b1);
    run_to_idle(400, 1'b0);
    cyc(1'b0, 1'b1, 8'd1, 8'd255, 1'b1, 1'b1);
    run_to_idle(700, 1'b0);

    // Randomized layers.
    for (int l = 0; l < 40; l++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        cyc(1'b0, ($urandom_range(0, 1) == 1), 8'd0, 8'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1), 1'b1);
      cyc(1'b0, 1'b1, 8'($urandom_range(1, 6)), 8'($urandom_range(1, 4)),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 9) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 8)); k++)
          cyc(1'b0, 1'b0, 8'd0, 8'd0, ($urandom_range(0, 1) == 1), 1'b1);
        cyc(1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
      end
      run_to_idle(500, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/agg_ctrl.md
# agg_ctrl

Sequencing controller for the aggregator (`agg`) datapath of the neural-network accelerator. For each output neuron of a layer, it counts a programmed number of partial sums into the aggregator. It then holds the finished result for the activation stage under a valid/ready handshake and steps to the next neuron until the layer is complete. It generates the aggregator clear and accumulate strobes, so the aggregator itself stays a pure datapath.

## Interface
Parameters:
- `cnt_width`, default 8: width of the term counter, the output counter and the length inputs.

Ports:
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: layer start pulse; honoured only in IDLE.
- `num_terms` input, `cnt_width` bits: partial sums per output; latched on an accepted `start`.
- `num_outputs` input, `cnt_width` bits: outputs per layer; latched on an accepted `start`.
- `in_valid` input, 1 bit: a partial sum is present on the aggregator input.
- `in_ready` output, 1 bit: the controller accepts a partial sum this cycle.
- `agg_en` output, 1 bit: aggregator accumulate strobe.
- `agg_clr` output, 1 bit: aggregator load-instead-of-add strobe, for the first term of an output.
- `act_valid` output, 1 bit: the aggregator result is complete and is offered to the activation stage.
- `act_ready` input, 1 bit: the activation stage takes the result.
- `out_idx` output, `cnt_width` bits: index of the output currently in progress.
- `busy` output, 1 bit: the controller is not in IDLE.
- `done` output, 1 bit: one-cycle pulse at the end of the layer.

## Operation
- States are IDLE, ACC, DRAIN and DONE. The FSM state, `term_cnt`, `out_idx`, and the latched `num_terms`/`num_outputs` are all registered.
- IDLE:
  - `start` with `num_terms != 0` and `num_outputs != 0` latches both lengths, clears `term_cnt` and `out_idx`, and moves to ACC.
  - `start` with either length equal to 0 is ignored, and the state stays IDLE.
- ACC:
  - `in_ready` = 1.
  - A cycle with `in_valid` = 1 is an accept; `term_cnt` increments on each accept.
  - On the accept where `term_cnt == num_terms-1`, `term_cnt` is cleared and the state moves to DRAIN.
- DRAIN:
  - `act_valid` = 1 and `in_ready` = 0.
  - When `act_ready` = 1 and `out_idx == num_outputs-1`, the state moves to DONE.
  - When `act_ready` = 1 otherwise, `out_idx` increments and the state moves to ACC.
  - `act_ready` = 0 holds DRAIN indefinitely.
- DONE: `done` = 1 for exactly one cycle, then the state moves to IDLE. `out_idx` holds its last value until the next accepted `start`.
- Strobe decoding:
  - `agg_en` = `in_valid & in_ready`.
  - `agg_clr` = `agg_en & (term_cnt == 0)`.
- Output sources:
  - `in_ready`, `act_valid`, `busy` and `done` decode from registered state only, with no combinational input path.
  - `agg_en` and `agg_clr` are combinational from `in_valid`.
- `start` is ignored in every state other than IDLE, and the latched lengths are not disturbed.
- `num_terms` = 1: every accept asserts both `agg_clr` and `agg_en`, and goes straight to DRAIN.
- Counters never wrap: the maximum value `2^cnt_width-1` is legal for both lengths.

## Timing
- Reset (`rst` = 1 at a rising edge):
  - Next cycle: state = IDLE, `term_cnt` = 0, `out_idx` = 0.
  - All outputs read 0, including `in_ready`, `act_valid`, `busy` and `done`.
- Reset mid-operation aborts the layer immediately. The aggregator sees no further strobes, and no `done` is emitted.
- Reset has priority over `start` in the same cycle.
- `start` accepted at edge k: ACC and `busy` = 1 from cycle k+1.
- With `in_valid` and `act_ready` held at 1:
  - N = `num_terms`, M = `num_outputs`.
  - Each output takes N+1 cycles: N in ACC and 1 in DRAIN.
  - `done` is asserted in cycle k+1+M·(N+1).
  - IDLE is reached in the following cycle.
- A gap in `in_valid` stretches ACC one cycle per idle cycle, and `term_cnt` holds during the gap.

## Configuration
- `AGG_CTRL_PERF_EN` defined:
  - Adds output `stall_cnt`, 16 bits, reset value 0.
  - It increments on each ACC cycle with `in_valid` = 0 and each DRAIN cycle with `act_ready` = 0.
  - It saturates at 16'hFFFF and clears on an accepted `start`.
- `AGG_CTRL_PERF_EN` undefined: the port and its counter are absent, and all other behaviour is identical.

## Test plan
- Reset and idle:
  - Stimulus: hold `rst` = 1 for 2 cycles, release, then hold `start` = 0 for 5 cycles.
  - Response: all outputs 0 throughout, including `busy`, `in_ready` and `act_valid`.
- Basic layer:
  - Stimulus: `num_terms` = 3, `num_outputs` = 2; `in_valid` and `act_ready` held at 1; `start` at edge 0.
  - Response: `agg_clr` in cycles 1 and 5; `agg_en` in cycles 1–3 and 5–7; `act_valid` in cycles 4 and 8; `out_idx` = 1 from cycle 5; `done` in cycle 9; `busy` = 0 from cycle 10.
- Backpressure:
  - Stimulus: `num_terms` = 2, `num_outputs` = 1; `act_ready` = 0 for 4 cycles in DRAIN.
  - Response: `act_valid` held for 5 cycles; no `agg_en`; with PERF enabled, `stall_cnt` = 4 at `done`.
- Input gaps:
  - Stimulus: `num_terms` = 4; `in_valid` pattern 1,0,1,1,0,1.
  - Response: exactly 4 `agg_en` pulses; `agg_clr` only on the first; DRAIN entered after the sixth ACC cycle.
- Illegal and ignored starts:
  - Stimulus: `start` with `num_terms` = 0, then a valid layer with `start` re-pulsed while in ACC.
  - Response: the first `start` leaves `busy` = 0; the re-pulse leaves the counters and `out_idx` unchanged.
- Reset mid-layer:
  - Stimulus: `rst` asserted in DRAIN with `out_idx` = 1.
  - Response: in the next cycle all outputs are 0 and `out_idx` = 0, and `done` is never pulsed.
